shared_port_arbiter: RTL and testbench
======================================

// Module: shared_port_arbiter
// PURPOSE
//  Two-requester round-robin arbiter for one shared datapath port (e.g. register-file write address/data).
//  Grants one requester at a time and drives the select of an internal mux_2_1 instance.
//  Registers the chosen operand for the shared resource.
//  Sits between the two producers and the shared port; the consumer sees one registered stream.
// PARAMETERS
//  WIDTH     5  datapath width of data0/data1/out_data
//  MAX_HOLD  4  max consecutive grant cycles while the other requester waits (>=1)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous reset, active-low
//  req0      in   1      requester 0 wants the port; held high while wanting
//  req1      in   1      requester 1 wants the port
//  data0     in   WIDTH  operand of requester 0 (mux in1)
//  data1     in   WIDTH  operand of requester 1 (mux in2)
//  gnt0      out  1      requester 0 owns the port this cycle
//  gnt1      out  1      requester 1 owns the port this cycle
//  select    out  1      mux select: 0 -> data0, 1 -> data1
//  out_data  out  WIDTH  registered operand of the granted requester
//  out_valid out  1      out_data valid
//  cnt0,cnt1 out  16     grant-cycle counters (ARB_PERF_CNT_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; gnt0=gnt1=0; select=0; out_data=0; out_valid=0; hold_cnt=0; last=1.
//    Effect is immediate, also mid-grant. last=1 makes req0 win the first tie.
//  FSM states: IDLE, GRANT0, GRANT1. gnt0=(state==GRANT0), gnt1=(state==GRANT1); never both high.
//  IDLE:
//    req0&req1 -> grant !last. Only one request -> grant that one. None -> stay.
//    Latency: request seen at edge N gives grant from edge N+1.
//  GRANTx:
//    Stay if reqx && !(hold_cnt==MAX_HOLD-1 && req_other).
//    Switch directly to GRANT_other if req_other && (!reqx || hold expired); no idle bubble.
//    !reqx && !req_other -> IDLE.
//  hold_cnt:
//    Clears on every state change; increments each GRANT cycle; saturates at MAX_HOLD-1.
//    Uncontested grant is unlimited. Width HOLD_W = max(1,$clog2(MAX_HOLD)).
//    MAX_HOLD=1 with both requesting: grant alternates every cycle.
//  last: updated to x on entry to GRANTx.
//  select: registered; equals granted index; holds last value in IDLE.
//  Datapath (1-cycle pipe):
//    out_valid(t+1) = gnt0|gnt1 at t.
//    out_data(t+1) = mux(select,data0,data1) at t when a grant is active; otherwise holds its value.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined:
//    cnt0/cnt1 increment on each gnt0/gnt1 cycle; saturate at 16'hFFFF; reset to 0.
//  ARB_PERF_CNT_EN undefined:
//    Ports cnt0/cnt1 are absent; no counter logic is built.
// STRUCTURE
//  Package arb_pkg:
//    state encoding IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10
//    PERF_CNT_W=16
//  Sub-module: one mux_2_1 #(.width(WIDTH)) instance
//    select -> select, in1 -> data0, in2 -> data1
//    Its output feeds the out_data register.
// TESTING (WIDTH=5, MAX_HOLD=4)
//  1 Reset mid-grant:
//    rst_n low while gnt1=1 -> gnt0/gnt1/select/out_valid/out_data = 0 before next edge.
//  2 Single request:
//    req0=1 for 3 cycles, data0=5'h0A -> gnt0 for 3 cycles starting 1 edge later.
//    out_valid=1 and out_data=5'h0A one cycle after each grant cycle.
//  3 Contention from reset:
//    req0=req1=1, data1=5'h15 -> gnt0 x4, gnt1 x4, repeating with no idle cycle.
//    out_data alternates 5'h0A/5'h15 in blocks of 4.
//  4 Uncontested hold:
//    req0 only for 10 cycles -> gnt0 high 10 consecutive cycles; no forced release.
//  5 Early release:
//    in GRANT0 with hold_cnt=1, req0 drops while req1=1 -> gnt1 on next edge; hold_cnt=0.
//  6 Counters (ARB_PERF_CNT_EN):
//    scenario 3 for 16 grant cycles -> cnt0=8, cnt1=8.
//    Force to 16'hFFFF -> stays 16'hFFFF.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester shared-port arbiter.
// ARB_PERF_CNT_EN (optional) enables the grant-cycle counters that use PERF_CNT_W.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_e;

    localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/mux_2_1.sv
// Two-input operand multiplexer; select=0 passes in1, select=1 passes in2.
module mux_2_1 #(
    parameter int width = 1
) (
    input  logic             select,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    output logic [width-1:0] out
);

    assign out = select ? in2 : in1;

endmodule

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter for two producers sharing one port, with a registered operand stage.
// Define ARB_PERF_CNT_EN to build the cnt0/cnt1 grant-cycle counter ports.
module shared_port_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             select,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] cnt0,
    output logic [PERF_CNT_W-1:0] cnt1
`endif
);

    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              last_q, last_d;
    logic              select_q, select_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  mux_out;
    logic              hold_expired;
    logic              granted;

    mux_2_1 #(.width(WIDTH)) u_mux (
        .select (select_q),
        .in1    (data0),
        .in2    (data1),
        .out    (mux_out)
    );

    assign gnt0      = (state_q == GRANT0);
    assign gnt1      = (state_q == GRANT1);
    assign granted   = gnt0 | gnt1;
    assign select    = select_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            last_q      <= 1'b1;
            select_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            select_q    <= select_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_expired = (hold_q == HOLD_LAST);

        unique case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = last_q ? GRANT0 : GRANT1;
                else if (req0)     state_d = GRANT0;
                else if (req1)     state_d = GRANT1;
            end
            // Hold expiry only forces a hand-over when the other side is waiting.
            GRANT0: begin
                if (req0 && !(hold_expired && req1)) state_d = GRANT0;
                else if (req1)                       state_d = GRANT1;
                else                                 state_d = IDLE;
            end
            GRANT1: begin
                if (req1 && !(hold_expired && req0)) state_d = GRANT1;
                else if (req0)                       state_d = GRANT0;
                else                                 state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        hold_d = hold_q;
        if (state_d != state_q) begin
            hold_d = '0;
        end else if (state_q != IDLE && !hold_expired) begin
            hold_d = hold_q + 1'b1;
        end

        last_d   = last_q;
        select_d = select_q;
        if (state_d == GRANT0) begin
            last_d   = 1'b0;
            select_d = 1'b0;
        end else if (state_d == GRANT1) begin
            last_d   = 1'b1;
            select_d = 1'b1;
        end

        out_valid_d = granted;
        out_data_d  = granted ? mux_out : out_data_q;
    end

`ifdef ARB_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
            if (gnt1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Scoreboard bench for shared_port_arbiter: a transaction-level ownership model predicts
// per-cycle grants and the registered operand stream; a monitor compares every cycle.
module tb_shared_port_arbiter;

    localparam int WIDTH    = 5;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, select, out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]      cnt0, cnt1;
`endif

    always #5 clk = ~clk;

    shared_port_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .select    (select),
        .out_data  (out_data),
        .out_valid (out_valid)
`ifdef ARB_PERF_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    typedef struct {
        logic        g0;
        logic        g1;
        logic        sel;
        logic        valid;
        logic [15:0] c0;
        logic [15:0] c1;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] data_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    bit               mon_en   = 1'b0;

    // Reference model: who owns the port, for how many consecutive cycles so far.
    int owner = -1;
    int run   = 0;
    bit last_m = 1'b1;
    bit sel_m  = 1'b0;
    int c0_m = 0, c1_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        data_q.delete();
        owner = -1; run = 0; last_m = 1'b1; sel_m = 1'b0; c0_m = 0; c1_m = 0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        #1;
        chk("rst_gnt0", {31'd0, gnt0}, 0);
        chk("rst_gnt1", {31'd0, gnt1}, 0);
        chk("rst_select", {31'd0, select}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {27'd0, out_data}, 0);
`ifdef ARB_PERF_CNT_EN
        chk("rst_cnt0", {16'd0, cnt0}, 0);
        chk("rst_cnt1", {16'd0, cnt1}, 0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Drive one cycle of inputs and predict the DUT state after the following edge.
    task automatic step(input logic r0, input logic r1,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        int   nxt;
        bit   mine, other;
        exp_t e;
        @(negedge clk);
        req0 = r0; req1 = r1; data0 = d0; data1 = d1;

        if (owner >= 0) begin
            data_q.push_back(owner == 1 ? d1 : d0);
            if (owner == 0) c0_m = (c0_m == 16'hFFFF) ? c0_m : c0_m + 1;
            else            c1_m = (c1_m == 16'hFFFF) ? c1_m : c1_m + 1;
        end

        if (owner < 0) begin
            if (r0 && r1)  nxt = last_m ? 0 : 1;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else begin
            mine  = (owner == 1) ? r1 : r0;
            other = (owner == 1) ? r0 : r1;
            if (mine && !(other && run >= MAX_HOLD)) nxt = owner;
            else if (other)                          nxt = 1 - owner;
            else                                     nxt = -1;
        end

        e.valid = (owner >= 0);
        if (nxt >= 0) begin
            run    = (nxt == owner) ? run + 1 : 1;
            sel_m  = (nxt == 1);
            last_m = (nxt == 1);
        end else begin
            run = 0;
        end
        owner = nxt;

        e.g0  = (nxt == 0);
        e.g1  = (nxt == 1);
        e.sel = sel_m;
        e.c0  = 16'(c0_m);
        e.c1  = 16'(c1_m);
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL exp_queue: got empty expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt0", {31'd0, gnt0}, {31'd0, e.g0});
                    chk("gnt1", {31'd0, gnt1}, {31'd0, e.g1});
                    chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
                    chk("select", {31'd0, select}, {31'd0, e.sel});
                    chk("out_valid", {31'd0, out_valid}, {31'd0, e.valid});
`ifdef ARB_PERF_CNT_EN
                    chk("cnt0", {16'd0, cnt0}, {16'd0, e.c0});
                    chk("cnt1", {16'd0, cnt1}, {16'd0, e.c1});
`endif
                    if (out_valid) begin
                        if (data_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL out_data: got %0h expected no valid data at %0t",
                                     out_data, $time);
                        end else begin
                            chk("out_data", {27'd0, out_data}, {27'd0, data_q.pop_front()});
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = '0;
        data1 = '0;
        do_reset();

        repeat (3) step(1'b1, 1'b0, 5'h0A, 5'h15);
        repeat (3) step(1'b0, 1'b0, 5'h0A, 5'h15);

        repeat (20) step(1'b1, 1'b1, 5'h0A, 5'h15);
        repeat (2) step(1'b0, 1'b0, 5'h0A, 5'h15);

        repeat (10) step(1'b1, 1'b0, 5'h0A, 5'h15);
        repeat (2) step(1'b0, 1'b0, 5'h0A, 5'h15);

        step(1'b1, 1'b0, 5'h03, 5'h1C);
        step(1'b1, 1'b1, 5'h04, 5'h1D);
        step(1'b0, 1'b1, 5'h05, 5'h1E);

        // Asynchronous reset while requester 1 owns the port.
        @(posedge clk);
        #3;
        do_reset();

        repeat (400) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 WIDTH'($urandom), WIDTH'($urandom));
        end
        repeat (3) step(1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        chk("data_queue_drained", data_q.size(), 0);
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
